memory: RTL and testbench

//   Word-addressed data memory with one synchronous write port and one combinational read port.

---
 rtl/memory.sv | 59 +++++
 tb/tb_memory.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/memory.sv
// Word-addressed data memory for the MEM stage: one synchronous write port, one combinational read port.
// Latency: a write takes effect at the rising edge; a read is combinational and has zero latency.
// Backpressure: none. A write is accepted on every edge with memwrite=1, and a read is always valid.
//
// Ports:
//   dira      - read word index; only [ADDR_BITS-1:0] are used
//   dirwrite  - write word index; only [ADDR_BITS-1:0] are used
//   datawrite - write data
//   clk       - clock; all state changes happen on its rising edge
//   memwrite  - write enable
//   memread   - read enable; a is 0 when this is low
//   a         - read data, equal to memread ? mem[dira] : 0
//   rst       - synchronous active-high reset; clears every word
//
// rst comes last in the port list so that older positional instantiations still connect correctly.
module memory #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic [31:0]      dira,
  input  logic [31:0]      dirwrite,
  input  logic [WIDTH-1:0] datawrite,
  input  logic             clk,
  input  logic             memwrite,
  input  logic             memread,
  output logic [WIDTH-1:0] a,
  input  logic             rst
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] rd_idx;
  logic [ADDR_BITS-1:0] wr_idx;

  // The upper address bits are dropped on purpose, so addresses wrap modulo DEPTH.
  assign rd_idx = dira[ADDR_BITS-1:0];
  assign wr_idx = dirwrite[ADDR_BITS-1:0];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{dira[31:ADDR_BITS], dirwrite[31:ADDR_BITS]};

  // Reset takes priority and discards any write in the same cycle.
  // An X or Z on memwrite makes the if condition false, so no write happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (memwrite) begin
      mem[wr_idx] <= datawrite;
    end
  end

  // datawrite is not forwarded onto a. A read from the address being written
  // shows the old word until the edge and the new word after it.
  assign a = memread ? mem[rd_idx] : '0;

endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: reset clear, write/read, combinational read, read enable, address wrap,
// X on the write enable, and reset overriding a write in the same cycle.
// The clock period is 20. Inputs change 1 time unit after a rising edge, and outputs are checked there too.
module tb_memory;

  logic        clk;
  logic        rst;
  logic [31:0] dira;
  logic [31:0] dirwrite;
  logic [31:0] datawrite;
  logic        memwrite;
  logic        memread;
  logic [31:0] a;

  int n_chk;
  int n_pass;

  memory #(32) dut (
    .dira      (dira),
    .dirwrite  (dirwrite),
    .datawrite (datawrite),
    .clk       (clk),
    .memwrite  (memwrite),
    .memread   (memread),
    .a         (a),
    .rst       (rst)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for the next rising edge, then step 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b1;
    dira      = 32'd0;
    dirwrite  = 32'd0;
    datawrite = 32'd0;
    memwrite  = 1'b0;
    memread   = 1'b1;

    // 1. A single reset edge clears the memory, so every address reads 0.
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dira = i;
      #1;
      chk($sformatf("reset_rd%0d", i), a, 32'd0);
    end

    // 2. Write 54 to address 5 while reading address 5.
    //    The read shows the old value before the edge and 54 after it.
    memwrite  = 1'b1;
    dirwrite  = 32'd5;
    datawrite = 32'd54;
    dira      = 32'd5;
    #1;
    chk("rdw_before_edge", a, 32'd0);
    tick();
    chk("rdw_after_edge", a, 32'd54);

    // 3. Write address 8 while reading address 5: both operations take effect.
    dirwrite  = 32'd8;
    datawrite = 32'd4;
    tick();
    chk("rd5_during_wr8", a, 32'd54);
    memwrite = 1'b0;
    dira     = 32'd8;
    #1;
    chk("comb_rd8", a, 32'd4);

    // 4. Contents hold with no write, and memread=0 forces a to 0.
    repeat (3) tick();
    dira = 32'd5;
    #1;
    chk("hold_rd5", a, 32'd54);
    memread = 1'b0;
    #1;
    chk("memread_low", a, 32'd0);
    memread = 1'b1;

    // 5. Address wrap on both ports: a write to 263 lands in word 7.
    memwrite  = 1'b1;
    dirwrite  = 32'd263;
    datawrite = 32'hDEADBEEF;
    tick();
    memwrite = 1'b0;
    dira     = 32'd7;
    #1;
    chk("wrap_wr_rd7", a, 32'hDEADBEEF);
    dira = 32'd261;
    #1;
    chk("wrap_rd261", a, 32'd54);

    // An unknown write enable must not write.
    memwrite  = 1'bx;
    dirwrite  = 32'd5;
    datawrite = 32'd99;
    tick();
    memwrite = 1'b0;
    dira     = 32'd5;
    #1;
    chk("x_memwrite", a, 32'd54);

    // 6. Reset wins over a write in the same cycle, and all earlier data is cleared.
    rst       = 1'b1;
    memwrite  = 1'b1;
    dirwrite  = 32'd9;
    datawrite = 32'd1;
    tick();
    rst      = 1'b0;
    memwrite = 1'b0;
    dira     = 32'd9;
    #1;
    chk("rst_drops_wr9", a, 32'd0);
    dira = 32'd5;
    #1;
    chk("rst_clears5", a, 32'd0);
    dira = 32'd7;
    #1;
    chk("rst_clears7", a, 32'd0);

    // A write after reset still works.
    memwrite  = 1'b1;
    dirwrite  = 32'd10;
    datawrite = 32'h1234_5678;
    tick();
    memwrite = 1'b0;
    dira     = 32'd10;
    #1;
    chk("post_rst_wr10", a, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
